// File: rtl/prism_config_reader_if.sv
// Host-bus side of the PRISM config readback: request, pointer load and
// response signals. The host (or a bench) uses the master modport, and the
// reader uses the slave modport.
interface prism_config_reader_if;
  logic        rd_req;
  logic        rd_sel;
  logic        idx_wr;
  logic [3:0]  idx_wdata;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        busy;
  logic [3:0]  entry_idx;
  logic        overrun;

  modport master (
    output rd_req, rd_sel, idx_wr, idx_wdata,
    input  rd_data, rd_valid, busy, entry_idx, overrun
  );

  modport slave (
    input  rd_req, rd_sel, idx_wr, idx_wdata,
    output rd_data, rd_valid, busy, entry_idx, overrun
  );
endinterface

// File: rtl/prism_config_reader.sv
// prism_config_reader: readback side of the PRISM latch config chain.
// A low-word read atomically snapshots the selected chain entry into a shadow
// register and returns bits [31:0]. A high-word read returns the upper bits of
// that snapshot and advances the entry pointer. Low-word reads issued while the
// loader is shifting the chain wait until the chain is stable.
// Optional feature macro: PRISM_READBACK_PARITY_EN. When it is defined,
// high-word reads carry an XOR checksum of the shadow bytes in [31:24].
module prism_config_reader #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH*DEPTH-1:0] config_bus,
  input  logic                   loader_busy,
  prism_config_reader_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] LAST_IDX = 4'(DEPTH - 1);

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   shadow_reg, shadow_next;
  logic [31:0]        rd_data_reg, rd_data_next;
  logic [3:0]         entry_idx_reg, entry_idx_next;
  logic               overrun_reg, overrun_next;

  logic [WIDTH-1:0]   entries [DEPTH];
  logic [WIDTH-1:0]   entry_sel;
  logic [3:0]         load_idx;
  logic [3:0]         eff_idx;
  logic [3:0]         adv_idx;
  logic [31:0]        hi_word;

  // Unpack the flat chain bus into one entry per element
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    assign entries[gi] = config_bus[(gi+1)*WIDTH-1 -: WIDTH];
  end

  // Out-of-range pointer loads saturate at the last entry
  assign load_idx = ({1'b0, bus.idx_wdata} >= 5'(DEPTH)) ? LAST_IDX : bus.idx_wdata;

  // A pointer load in IDLE takes effect before a same-cycle request
  assign eff_idx = (state_reg == IDLE && bus.idx_wr) ? load_idx : entry_idx_reg;

  // Pointer wraps after the last entry (DEPTH need not be a power of two)
  assign adv_idx = (eff_idx == LAST_IDX) ? 4'd0 : eff_idx + 4'd1;

  // Entry mux; eff_idx never exceeds DEPTH-1 so the default is unreachable
  always_comb begin
    entry_sel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (eff_idx == 4'(i)) entry_sel = entries[i];
    end
  end

`ifdef PRISM_READBACK_PARITY_EN
  logic [47:0] shadow_pad;
  logic [7:0]  parity;
  assign shadow_pad = 48'(shadow_reg);
  assign parity = shadow_pad[7:0]   ^ shadow_pad[15:8]  ^ shadow_pad[23:16] ^
                  shadow_pad[31:24] ^ shadow_pad[39:32] ^ shadow_pad[47:40];
  assign hi_word = {parity, 8'h00, shadow_pad[47:32]};
`else
  assign hi_word = {16'h0000, 16'(shadow_reg[WIDTH-1:32])};
`endif

  // Next-state and register-update logic
  always_comb begin
    state_next     = state_reg;
    shadow_next    = shadow_reg;
    rd_data_next   = rd_data_reg;
    entry_idx_next = entry_idx_reg;
    overrun_next   = overrun_reg;

    // Requests are not queued: anything arriving while busy is dropped
    if (bus.rd_req && state_reg != IDLE) overrun_next = 1'b1;

    case (state_reg)
      IDLE: begin
        if (bus.idx_wr) entry_idx_next = load_idx;
        if (bus.rd_req) begin
          if (bus.rd_sel) begin
            rd_data_next   = hi_word;
            entry_idx_next = adv_idx;
            state_next     = RESP;
          end else if (loader_busy) begin
            state_next = WAIT;
          end else begin
            shadow_next  = entry_sel;
            rd_data_next = entry_sel[31:0];
            state_next   = RESP;
          end
        end
      end
      WAIT: begin
        if (!loader_busy) begin
          shadow_next  = entry_sel;
          rd_data_next = entry_sel[31:0];
          state_next   = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State and data registers; reset also discards any in-flight response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      shadow_reg    <= '0;
      rd_data_reg   <= '0;
      entry_idx_reg <= '0;
      overrun_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      shadow_reg    <= shadow_next;
      rd_data_reg   <= rd_data_next;
      entry_idx_reg <= entry_idx_next;
      overrun_reg   <= overrun_next;
    end
  end

  assign bus.rd_data   = rd_data_reg;
  assign bus.rd_valid  = (state_reg == RESP);
  assign bus.busy      = (state_reg != IDLE);
  assign bus.entry_idx = entry_idx_reg;
  assign bus.overrun   = overrun_reg;

endmodule
